period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Receive-side companion to the team's clock divider: measures an incoming slow square wave (a divided clock or an external tick) in units of clk cycles.
- Each full cycle of the input produces a period count and a high-time count.
- Also flags lock (input toggling regularly) and timeout (input stalled).
- Sits beside divider outputs or external timing inputs to check them or feed them back to software.

Parameters:
- COUNT_WIDTH, 32, width of the period/high counters and result outputs.
- TIMEOUT_CYCLES, 40000000, cycles without a rising edge before timeout. Must be ≥ 2 and < 2^COUNT_WIDTH.
- SYNC_STAGES, 2, flip-flops in the sig_in synchronizer. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  measured signal; asynchronous to clk.
- enable  input  1  high = measure; low = hold in IDLE.
- period_out  output  COUNT_WIDTH  last measured period in clk cycles.
- high_out  output  COUNT_WIDTH  last measured high time in clk cycles.
- meas_valid  output  1  one-cycle pulse when period_out/high_out update.
- locked  output  1  at least one complete measurement since the last arm/timeout.
- timeout  output  1  sticky stall flag.

Behaviour:
- Reset (asynchronous, rst=1): all outputs are 0, state=IDLE, counters and synchronizer are 0.
- Input path:
  - sig_in passes through SYNC_STAGES flops to give s, then one more flop gives s_d.
  - rise = s & ~s_d.
  - rise is registered internally; there is no glitch filtering.
- States:
  - IDLE: counters held at 0; locked=0. Go to ARM when enable=1.
  - ARM: wait for rise. On rise: cnt←1, hcnt←1, go to MEAS. No output change on this first rise.
  - MEAS, every cycle with no rise: cnt←cnt+1; hcnt←hcnt+s.
  - MEAS, on rise:
    - period_out←cnt, high_out←hcnt, meas_valid=1 on the next cycle.
    - locked←1, timeout←0.
    - cnt←1, hcnt←1.
- Result of a rise: period_out = clk cycles between consecutive rises; high_out = cycles s was high within that period.
- Timeout:
  - Applies in MEAS, or in ARM with its own cnt running.
  - If cnt reaches TIMEOUT_CYCLES with no rise: timeout←1, locked←0, go to ARM.
  - period_out and high_out are retained.
  - In ARM, cnt counts from entry so a dead input also times out; it is cleared on rise or on reaching TIMEOUT_CYCLES.
- Rise on the same cycle as the timeout condition: rise wins. Result is accepted with period_out=TIMEOUT_CYCLES; no timeout.
- enable falls: go to IDLE immediately.
  - locked←0; timeout holds its value.
  - A rise on the same cycle is ignored and gives no meas_valid.
  - Results hold their values.
- Clearing timeout: only by a valid measurement, by rst, or by the enable 0→1 transition (cleared on entry to ARM).
- Arithmetic: unsigned. Counters never exceed TIMEOUT_CYCLES, so no wrap occurs.
- meas_valid is exactly one cycle wide. Consecutive pulses are separated by ≥ 2 cycles, which is the minimum detectable period.
- Latency: sig_in rising edge → meas_valid is SYNC_STAGES+2 clk cycles (sync stages + edge flop + result register).
- rst mid-measurement: immediate return to reset values; the first result after release needs two rises.

Test Plan:
- Reset, enable=1, sig_in period 10 (5 high/5 low) → first meas_valid after the 2nd rise; period_out=10, high_out=5, locked=1; repeats every 10 cycles.
- Duty change to 3 high/7 low, then period 20 (12 high) → next results 10/3, then 20/12; meas_valid stays one cycle per period.
- sig_in held low, TIMEOUT_CYCLES=100 → timeout=1, locked=0, previous results retained; resume toggling → timeout clears on the first valid result.
- Rise exactly at cnt=TIMEOUT_CYCLES (period 100) → period_out=100, timeout stays 0.
- enable dropped on the same cycle as a rise → no meas_valid, locked=0; re-enable → two rises needed before a new result.
- rst asserted asynchronously mid-period → all outputs 0 immediately; minimum period 2 (toggle every cycle) afterwards → period_out=2, high_out=1.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures an incoming slow square wave in clk cycles.
// Every full input cycle (rise to rise) yields a period count and a
// high-time count. Also reports lock (regular toggling) and a sticky
// timeout when the input stalls.
//
// Parameters:
//   COUNT_WIDTH    - width of counters and result outputs
//   TIMEOUT_CYCLES - cycles without a rising edge before timeout
//   SYNC_STAGES    - synchronizer depth for sig_in (>= 2)
// Ports:
//   clk        - system clock, posedge
//   rst        - asynchronous active-high reset
//   sig_in     - measured signal, asynchronous to clk
//   enable     - 1 = measure, 0 = hold in IDLE
//   period_out - last measured period in clk cycles
//   high_out   - last measured high time in clk cycles
//   meas_valid - one-cycle pulse when results update
//   locked     - a complete measurement since the last arm/timeout
//   timeout    - sticky stall flag
module period_meter #(
    parameter int unsigned COUNT_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 40000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sig_in,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] period_out,
    output logic [COUNT_WIDTH-1:0] high_out,
    output logic                   meas_valid,
    output logic                   locked,
    output logic                   timeout
);

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);

    // Elaboration-time parameter sanity checks
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("period_meter: SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_lo
        $error("period_meter: TIMEOUT_CYCLES must be >= 2");
    end
    if ((64'(TIMEOUT_CYCLES) >> COUNT_WIDTH) != 64'd0) begin : g_bad_timeout_hi
        $error("period_meter: TIMEOUT_CYCLES must fit in COUNT_WIDTH bits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise_r;

    logic [COUNT_WIDTH-1:0] cnt, cnt_n;
    logic [COUNT_WIDTH-1:0] hcnt, hcnt_n;
    logic [COUNT_WIDTH-1:0] period_n, high_n;
    logic                   valid_n, locked_n, timeout_n;

    assign s = sync_q[SYNC_STAGES-1];

    // Input synchronizer, delayed copy and registered rising-edge strobe.
    // s_d is aligned with rise_r, so it is the level used for high time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
            rise_r <= s & ~s_d;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hcnt       <= hcnt_n;
            period_out <= period_n;
            high_out   <= high_n;
            meas_valid <= valid_n;
            locked     <= locked_n;
            timeout    <= timeout_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hcnt_n    = hcnt;
        period_n  = period_out;
        high_n    = high_out;
        valid_n   = 1'b0;
        locked_n  = locked;
        timeout_n = timeout;

        case (state)
            IDLE: begin
                cnt_n    = '0;
                hcnt_n   = '0;
                locked_n = 1'b0;
                if (enable) begin
                    state_n   = ARM;
                    timeout_n = 1'b0;
                end
            end

            ARM: begin
                if (!enable) begin
                    state_n  = IDLE;
                    locked_n = 1'b0;
                    cnt_n    = '0;
                    hcnt_n   = '0;
                end else if (rise_r) begin
                    // First rise only starts a measurement
                    state_n = MEAS;
                    cnt_n   = ONE;
                    hcnt_n  = ONE;
                end else if (cnt == TIMEOUT_VAL) begin
                    timeout_n = 1'b1;
                    locked_n  = 1'b0;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end

            MEAS: begin
                if (!enable) begin
                    state_n  = IDLE;
                    locked_n = 1'b0;
                    cnt_n    = '0;
                    hcnt_n   = '0;
                end else if (rise_r) begin
                    // A rise on the timeout cycle still counts as a result
                    period_n  = cnt;
                    high_n    = hcnt;
                    valid_n   = 1'b1;
                    locked_n  = 1'b1;
                    timeout_n = 1'b0;
                    cnt_n     = ONE;
                    hcnt_n    = ONE;
                end else if (cnt == TIMEOUT_VAL) begin
                    state_n   = ARM;
                    timeout_n = 1'b1;
                    locked_n  = 1'b0;
                    cnt_n     = '0;
                    hcnt_n    = '0;
                end else begin
                    cnt_n  = cnt + ONE;
                    hcnt_n = hcnt + COUNT_WIDTH'(s_d);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: directed stimulus with a scoreboard of
// expected (period, high) results, compared whenever meas_valid pulses.
module tb_period_meter;

    localparam int unsigned CW = 32;

    logic          clk;
    logic          rst;
    logic          sig_in;
    logic          enable;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic          meas_valid;
    logic          locked;
    logic          timeout;

    period_meter #(
        .COUNT_WIDTH   (CW),
        .TIMEOUT_CYCLES(100),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .enable    (enable),
        .period_out(period_out),
        .high_out  (high_out),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] exp_p[$];
    logic [CW-1:0] exp_h[$];

    bit            prev_valid = 1'b0;
    logic [CW-1:0] prev_p;
    logic [CW-1:0] prev_h;
    logic          last_mv = 1'b0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One input cycle; each rise completes the previous cycle's result
    task automatic cyc(input int hi, input int lo);
        if (prev_valid) begin
            exp_p.push_back(prev_p);
            exp_h.push_back(prev_h);
        end
        sig_in = 1'b1;
        step(hi);
        sig_in = 1'b0;
        step(lo);
        prev_valid = 1'b1;
        prev_p     = CW'(hi + lo);
        prev_h     = CW'(hi);
    endtask

    // Scoreboard: pop and compare on every meas_valid
    always @(negedge clk) begin
        if (!rst) begin
            if (meas_valid) begin
                check("valid_single_cycle", CW'(last_mv), CW'(0));
                check("valid_expected", CW'(exp_p.size() > 0), CW'(1));
                if (exp_p.size() > 0) begin
                    check("period_out", period_out, exp_p.pop_front());
                    check("high_out", high_out, exp_h.pop_front());
                end
            end
            last_mv = meas_valid;
        end else begin
            last_mv = 1'b0;
        end
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        enable = 1'b0;
        step(2);
        check("rst_period", period_out, 0);
        check("rst_high", high_out, 0);
        check("rst_valid", CW'(meas_valid), 0);
        check("rst_locked", CW'(locked), 0);
        check("rst_timeout", CW'(timeout), 0);
        rst = 1'b0;
        step(2);
        enable = 1'b1;
        step(3);

        // Period 10, 5 high
        repeat (4) cyc(5, 5);
        check("lock_after_10", CW'(locked), 1);
        check("no_timeout_10", CW'(timeout), 0);

        // Duty change then period 20 with 12 high
        cyc(3, 7);
        cyc(12, 8);
        cyc(12, 8);

        // Stall: the in-progress period times out
        prev_valid = 1'b0;
        step(130);
        check("stall_timeout", CW'(timeout), 1);
        check("stall_locked", CW'(locked), 0);
        check("stall_period_kept", period_out, 20);
        check("stall_high_kept", high_out, 12);

        // Resume: two rises needed, timeout clears on first result
        repeat (3) cyc(5, 5);
        check("resume_timeout", CW'(timeout), 0);
        check("resume_locked", CW'(locked), 1);

        // Rise exactly at the timeout count: accepted
        repeat (2) cyc(50, 50);
        cyc(5, 5);
        check("edge_period", period_out, 100);
        check("edge_high", high_out, 50);
        check("edge_timeout", CW'(timeout), 0);
        check("edge_locked", CW'(locked), 1);

        // Drop enable on the cycle the rise reaches the FSM
        sig_in = 1'b1;
        step(3);
        enable = 1'b0;
        prev_valid = 1'b0;
        step(2);
        check("dis_locked", CW'(locked), 0);
        check("dis_timeout", CW'(timeout), 0);
        check("dis_period_kept", period_out, 100);
        step(2);
        sig_in = 1'b0;
        step(5);
        enable = 1'b1;
        step(3);
        repeat (3) cyc(5, 5);
        check("reen_locked", CW'(locked), 1);
        check("reen_period", period_out, 10);

        // Asynchronous reset mid-period
        sig_in = 1'b1;
        step(2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_period", period_out, 0);
        check("arst_high", high_out, 0);
        check("arst_valid", CW'(meas_valid), 0);
        check("arst_locked", CW'(locked), 0);
        check("arst_timeout", CW'(timeout), 0);
        step(2);
        rst = 1'b0;
        sig_in = 1'b0;
        prev_valid = 1'b0;
        step(4);

        // Minimum period: toggle every cycle
        repeat (6) cyc(1, 1);
        step(8);
        check("min_period", period_out, 2);
        check("min_high", high_out, 1);
        check("min_locked", CW'(locked), 1);
        check("queue_drained", CW'(exp_p.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
